// File: rtl/accel_spi_responder_if.sv
// ---------------------------------------------------------------------------
// accel_spi_responder_if
// Purpose : groups the four SPI wires between a bus master and the
//           accelerometer-style register responder.
// Signals : sclk - serial clock from the master (mode 0, idles low)
//           mosi - master-out / slave-in data
//           ss   - slave select, active low
//           miso - master-in / slave-out data
// Modports: master drives sclk/mosi/ss and reads miso; slave is the reverse.
// ---------------------------------------------------------------------------
interface accel_spi_responder_if;
   logic sclk;
   logic mosi;
   logic ss;
   logic miso;

   modport master (output sclk, output mosi, output ss, input miso);
   modport slave  (input sclk, input mosi, input ss, output miso);
endinterface

// File: rtl/accel_spi_responder.sv
// ---------------------------------------------------------------------------
// accel_spi_responder
// Purpose : SPI mode-0 slave exposing a small accelerometer register map.
//           sclk/mosi/ss are oversampled by clk; nothing runs on sclk.
//           Command byte 0x0A = write, 0x0B = read, anything else is
//           ignored after the address byte. Reads snapshot the three axis
//           samples once per transaction; the address pointer
//           auto-increments and wraps 0xFF -> 0x00.
// Ports   : clk         - system clock (only clock)
//           rst_n       - asynchronous active-low reset
//           spi         - SPI wires (slave modport)
//           x/y/z_data_i- 12-bit two's-complement axis samples
//           wr_valid_o  - one-clk pulse per accepted write byte
//           wr_addr_o   - address of the last accepted write
//           wr_data_o   - data of the last accepted write
//           power_ctl_o - POWER_CTL (0x2D) contents
//           busy_o      - high while synchronized ss is low
// ---------------------------------------------------------------------------
module accel_spi_responder #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] DEVID_AD    = 8'hAD,
   parameter logic [7:0] PARTID      = 8'hF2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   accel_spi_responder_if.slave spi,
   input  logic [11:0]          x_data_i,
   input  logic [11:0]          y_data_i,
   input  logic [11:0]          z_data_i,
   output logic                 wr_valid_o,
   output logic [7:0]           wr_addr_o,
   output logic [7:0]           wr_data_o,
   output logic [7:0]           power_ctl_o,
   output logic                 busy_o
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CMD    = 3'd1;
   localparam logic [2:0] ST_ADDR   = 3'd2;
   localparam logic [2:0] ST_WRITE  = 3'd3;
   localparam logic [2:0] ST_READ   = 3'd4;
   localparam logic [2:0] ST_IGNORE = 3'd5;

   localparam logic [7:0] CMD_WRITE = 8'h0A;
   localparam logic [7:0] CMD_READ  = 8'h0B;
   localparam logic [7:0] FILTER_RST = 8'h13;

   // Synchronizer chain: bit 2 = ss, bit 1 = mosi, bit 0 = sclk.
   // Reset value models an idle bus (ss high, sclk low, mosi low).
   logic [2:0] sync_q [SYNC_STAGES];

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync_q[gi] <= 3'b100;
            end else if (gi == 0) begin
               sync_q[gi] <= {spi.ss, spi.mosi, spi.sclk};
            end else begin
               sync_q[gi] <= sync_q[(gi == 0) ? 0 : gi - 1];
            end
         end
      end
   endgenerate

   logic ss_s, mosi_s, sclk_s;
   assign ss_s   = sync_q[SYNC_STAGES-1][2];
   assign mosi_s = sync_q[SYNC_STAGES-1][1];
   assign sclk_s = sync_q[SYNC_STAGES-1][0];

   // fill_q tracks how far real samples have propagated since reset, so the
   // reset value of the ss chain is never mistaken for a genuine idle bus.
   logic [SYNC_STAGES-1:0] fill_q;
   logic ss_prev_q, sclk_prev_q, armed_q, armed_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_q      <= '0;
         ss_prev_q   <= 1'b1;
         sclk_prev_q <= 1'b0;
         armed_q     <= 1'b0;
      end else begin
         fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
         ss_prev_q   <= ss_s;
         sclk_prev_q <= sclk_s;
         armed_q     <= armed_d;
      end
   end

   // A frame may only start once ss has been truly observed high; this
   // drops the tail of a frame that was cut by reset.
   assign armed_d = armed_q | (fill_q[SYNC_STAGES-1] & ss_s);

   logic sclk_rise, sclk_fall, ss_fall;
   assign sclk_rise = ~sclk_prev_q & sclk_s;
   assign sclk_fall = sclk_prev_q & ~sclk_s;
   assign ss_fall   = armed_q & ss_prev_q & ~ss_s;

   logic [2:0]  state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [6:0]  shift_q, shift_d;
   logic [7:0]  cmd_q, cmd_d;
   logic [7:0]  ptr_q, ptr_d;
   logic [6:0]  tx_q, tx_d;
   logic        miso_q, miso_d;
   logic        wr_valid_q, wr_valid_d;
   logic [7:0]  wr_addr_q, wr_addr_d;
   logic [7:0]  wr_data_q, wr_data_d;
   logic [7:0]  filter_q, filter_d;
   logic [7:0]  power_q, power_d;
   logic [11:0] snap_x_q, snap_x_d;
   logic [11:0] snap_y_q, snap_y_d;
   logic [11:0] snap_z_q, snap_z_d;

   logic [7:0] rx_byte;
   logic       byte_done;
   logic [7:0] rd_byte;

   assign rx_byte   = {shift_q, mosi_s};
   assign byte_done = sclk_rise & (bit_cnt_q == 3'd7);

   // Read map, served from the per-transaction axis snapshot.
   always_comb begin
      rd_byte = 8'h00;
      case (ptr_q)
         8'h00: rd_byte = DEVID_AD;
         8'h01: rd_byte = 8'h1D;
         8'h02: rd_byte = PARTID;
         8'h0E: rd_byte = snap_x_q[7:0];
         8'h0F: rd_byte = {{4{snap_x_q[11]}}, snap_x_q[11:8]};
         8'h10: rd_byte = snap_y_q[7:0];
         8'h11: rd_byte = {{4{snap_y_q[11]}}, snap_y_q[11:8]};
         8'h12: rd_byte = snap_z_q[7:0];
         8'h13: rd_byte = {{4{snap_z_q[11]}}, snap_z_q[11:8]};
         8'h2C: rd_byte = filter_q;
         8'h2D: rd_byte = power_q;
         default: rd_byte = 8'h00;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      cmd_d      = cmd_q;
      ptr_d      = ptr_q;
      tx_d       = tx_q;
      miso_d     = (state_q == ST_READ) ? miso_q : 1'b0;
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      filter_d   = filter_q;
      power_d    = power_q;
      snap_x_d   = snap_x_q;
      snap_y_d   = snap_y_q;
      snap_z_d   = snap_z_q;

      if (ss_s) begin
         // Deselect aborts everything; a partial byte is simply dropped.
         state_d   = ST_IDLE;
         bit_cnt_d = 3'd0;
         miso_d    = 1'b0;
      end else if (state_q == ST_IDLE) begin
         if (ss_fall) begin
            state_d   = ST_CMD;
            bit_cnt_d = 3'd0;
         end
      end else begin
         if (sclk_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = rx_byte[6:0];
         end
         case (state_q)
            ST_CMD: begin
               if (byte_done) begin
                  cmd_d   = rx_byte;
                  state_d = ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (byte_done) begin
                  ptr_d = rx_byte;
                  if (cmd_q == CMD_READ) begin
                     state_d  = ST_READ;
                     snap_x_d = x_data_i;
                     snap_y_d = y_data_i;
                     snap_z_d = z_data_i;
                  end else if (cmd_q == CMD_WRITE) begin
                     state_d = ST_WRITE;
                  end else begin
                     state_d = ST_IGNORE;
                  end
               end
            end
            ST_WRITE: begin
               if (byte_done) begin
                  wr_valid_d = 1'b1;
                  wr_addr_d  = ptr_q;
                  wr_data_d  = rx_byte;
                  ptr_d      = ptr_q + 8'd1;
                  if (ptr_q == 8'h1F && rx_byte == 8'h52) begin
                     filter_d = FILTER_RST;
                     power_d  = 8'h00;
                  end else if (ptr_q == 8'h2C) begin
                     filter_d = rx_byte;
                  end else if (ptr_q == 8'h2D) begin
                     power_d = rx_byte;
                  end
               end
            end
            ST_READ: begin
               if (byte_done) begin
                  ptr_d = ptr_q + 8'd1;
               end
               // The first falling edge of each byte (counter at 0) loads
               // the byte at the pointer; later edges shift it out.
               if (sclk_fall) begin
                  if (bit_cnt_q == 3'd0) begin
                     miso_d = rd_byte[7];
                     tx_d   = rd_byte[6:0];
                  end else begin
                     miso_d = tx_q[6];
                     tx_d   = {tx_q[5:0], 1'b0};
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 7'd0;
         cmd_q      <= 8'h00;
         ptr_q      <= 8'h00;
         tx_q       <= 7'd0;
         miso_q     <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= 8'h00;
         wr_data_q  <= 8'h00;
         filter_q   <= FILTER_RST;
         power_q    <= 8'h00;
         snap_x_q   <= 12'h000;
         snap_y_q   <= 12'h000;
         snap_z_q   <= 12'h000;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         cmd_q      <= cmd_d;
         ptr_q      <= ptr_d;
         tx_q       <= tx_d;
         miso_q     <= miso_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         filter_q   <= filter_d;
         power_q    <= power_d;
         snap_x_q   <= snap_x_d;
         snap_y_q   <= snap_y_d;
         snap_z_q   <= snap_z_d;
      end
   end

   // miso is forced low straight from the pin whenever the master
   // deselects, without waiting for the synchronizer.
   assign spi.miso    = spi.ss ? 1'b0 : miso_q;
   assign wr_valid_o  = wr_valid_q;
   assign wr_addr_o   = wr_addr_q;
   assign wr_data_o   = wr_data_q;
   assign power_ctl_o = power_q;
   assign busy_o      = ~ss_s;

endmodule

// File: tb/tb_accel_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_accel_spi_responder
// Directed bench: a table of SPI transactions with hand-computed miso bytes,
// write pulses and POWER_CTL values, plus hand-written sequences for the
// axis snapshot, an aborted partial byte and reset asserted mid-read.
// Time unit is arbitrary; clk period is 10 units, sclk half-period 500
// (clk/100) for the first vector and 100 (clk/20) otherwise.
// ---------------------------------------------------------------------------
module tb_accel_spi_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] x_data, y_data, z_data;
   logic        wr_valid;
   logic [7:0]  wr_addr, wr_data, power_ctl;
   logic        busy;

   accel_spi_responder_if spi_if ();

   accel_spi_responder dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .spi         (spi_if.slave),
      .x_data_i    (x_data),
      .y_data_i    (y_data),
      .z_data_i    (z_data),
      .wr_valid_o  (wr_valid),
      .wr_addr_o   (wr_addr),
      .wr_data_o   (wr_data),
      .power_ctl_o (power_ctl),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int sclk_half = 100;

   // Write-pulse log, sampled on the falling clk edge.
   int         wr_cnt = 0;
   logic [7:0] log_a [64];
   logic [7:0] log_d [64];

   always @(negedge clk) begin
      if (wr_valid === 1'b1) begin
         log_a[wr_cnt % 64] = wr_addr;
         log_d[wr_cnt % 64] = wr_data;
         wr_cnt = wr_cnt + 1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
      end
   endtask

   // Mode-0 master: mosi set while sclk low, miso sampled at the rising edge.
   task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         spi_if.mosi = tx[i];
         #(sclk_half);
         spi_if.sclk = 1'b1;
         rx[i] = spi_if.miso;
         #(sclk_half);
         spi_if.sclk = 1'b0;
      end
   endtask

   task automatic frame_end();
      #(sclk_half);
      spi_if.ss = 1'b1;
      #200;
   endtask

   typedef struct {
      logic [7:0]  cmd;
      logic [7:0]  addr;
      int          nb;     // data bytes after the address
      logic [31:0] din;    // mosi data bytes, first byte in [31:24]
      logic [31:0] dexp;   // expected miso data bytes, same packing
      int          nwr;    // expected wr_valid pulses
      logic [7:0]  wa0;    // address of first pulse
      logic [7:0]  wa;     // address of last pulse
      logic [7:0]  wd;     // data of last pulse
      logic [7:0]  pwr;    // POWER_CTL afterwards
   } vec_t;

   localparam int NV = 12;
   vec_t vecs [NV];

   logic [7:0] rx;
   int         base;

   initial begin
      vecs[0]  = '{8'h0B, 8'h00, 3, 32'h0,         32'hAD1DF200, 0, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[1]  = '{8'h0B, 8'h10, 4, 32'h0,         32'hA50700F8, 0, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[2]  = '{8'h0A, 8'h2D, 1, 32'h02000000,  32'h0,        1, 8'h2D, 8'h2D, 8'h02, 8'h02};
      vecs[3]  = '{8'h0B, 8'h2C, 2, 32'h0,         32'h13020000, 0, 8'h00, 8'h00, 8'h00, 8'h02};
      vecs[4]  = '{8'h0A, 8'hFF, 2, 32'h11220000,  32'h0,        2, 8'hFF, 8'h00, 8'h22, 8'h02};
      vecs[5]  = '{8'h0B, 8'hFF, 2, 32'h0,         32'h00AD0000, 0, 8'h00, 8'h00, 8'h00, 8'h02};
      vecs[6]  = '{8'h0A, 8'h2C, 1, 32'h55000000,  32'h0,        1, 8'h2C, 8'h2C, 8'h55, 8'h02};
      vecs[7]  = '{8'h0B, 8'h2C, 2, 32'h0,         32'h55020000, 0, 8'h00, 8'h00, 8'h00, 8'h02};
      vecs[8]  = '{8'h33, 8'h00, 1, 32'hFF000000,  32'h0,        0, 8'h00, 8'h00, 8'h00, 8'h02};
      vecs[9]  = '{8'h0A, 8'h20, 1, 32'h11000000,  32'h0,        1, 8'h20, 8'h20, 8'h11, 8'h02};
      vecs[10] = '{8'h0A, 8'h1F, 1, 32'h52000000,  32'h0,        1, 8'h1F, 8'h1F, 8'h52, 8'h00};
      vecs[11] = '{8'h0B, 8'h2C, 2, 32'h0,         32'h13000000, 0, 8'h00, 8'h00, 8'h00, 8'h00};

      spi_if.ss   = 1'b1;
      spi_if.sclk = 1'b0;
      spi_if.mosi = 1'b0;
      rst_n  = 1'b0;
      x_data = 12'hF83;
      y_data = 12'h7A5;
      z_data = 12'h800;

      #100;
      chk("rst_miso", 0, {31'd0, spi_if.miso}, 32'd0);
      chk("rst_wr_valid", 0, {31'd0, wr_valid}, 32'd0);
      chk("rst_wr_addr", 0, {24'd0, wr_addr}, 32'h00);
      chk("rst_wr_data", 0, {24'd0, wr_data}, 32'h00);
      chk("rst_power_ctl", 0, {24'd0, power_ctl}, 32'h00);
      chk("rst_busy", 0, {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      #100;

      // ---------------- table-driven transactions ----------------
      for (int vi = 0; vi < NV; vi++) begin
         sclk_half = (vi == 0) ? 500 : 100;
         base = wr_cnt;
         spi_if.ss = 1'b0;
         #(sclk_half);
         xfer(vecs[vi].cmd, 8, rx);
         xfer(vecs[vi].addr, 8, rx);
         for (int b = 0; b < vecs[vi].nb; b++) begin
            xfer(vecs[vi].din[31-8*b -: 8], 8, rx);
            chk("miso_byte", vi*4 + b, {24'd0, rx}, {24'd0, vecs[vi].dexp[31-8*b -: 8]});
         end
         frame_end();
         chk("wr_count", vi, wr_cnt - base, vecs[vi].nwr);
         if (vecs[vi].nwr > 0) begin
            chk("wr_first_addr", vi, {24'd0, log_a[base % 64]}, {24'd0, vecs[vi].wa0});
            chk("wr_last_addr", vi, {24'd0, log_a[(base + vecs[vi].nwr - 1) % 64]}, {24'd0, vecs[vi].wa});
            chk("wr_last_data", vi, {24'd0, log_d[(base + vecs[vi].nwr - 1) % 64]}, {24'd0, vecs[vi].wd});
            chk("wr_addr_hold", vi, {24'd0, wr_addr}, {24'd0, vecs[vi].wa});
         end
         chk("power_ctl", vi, {24'd0, power_ctl}, {24'd0, vecs[vi].pwr});
         chk("idle_busy", vi, {31'd0, busy}, 32'd0);
         chk("idle_miso", vi, {31'd0, spi_if.miso}, 32'd0);
         $display("vector %0d: cmd %h addr %h bytes %0d writes %0d", vi, vecs[vi].cmd,
                  vecs[vi].addr, vecs[vi].nb, wr_cnt - base);
      end

      sclk_half = 100;

      // ---------------- axis snapshot held across the read ----------------
      x_data = 12'hF83;
      spi_if.ss = 1'b0;
      #(sclk_half);
      xfer(8'h0B, 8, rx);
      chk("busy_in_frame", 0, {31'd0, busy}, 32'd1);
      xfer(8'h0E, 8, rx);
      x_data = 12'h001;
      xfer(8'h00, 8, rx);
      chk("snap_x_lo", 0, {24'd0, rx}, 32'h83);
      xfer(8'h00, 8, rx);
      chk("snap_x_hi", 0, {24'd0, rx}, 32'hFF);
      frame_end();
      $display("snapshot read: x changed after address byte");

      // ---------------- partial byte discarded ----------------
      base = wr_cnt;
      spi_if.ss = 1'b0;
      #(sclk_half);
      xfer(8'h0A, 8, rx);
      xfer(8'h2D, 8, rx);
      xfer(8'h40, 8, rx);
      frame_end();
      chk("pwr_set", 0, {24'd0, power_ctl}, 32'h40);
      base = wr_cnt;
      spi_if.ss = 1'b0;
      #(sclk_half);
      xfer(8'h0A, 8, rx);
      xfer(8'h2D, 8, rx);
      xfer(8'hFF, 5, rx);
      frame_end();
      chk("partial_wr_count", 0, wr_cnt - base, 0);
      chk("partial_power", 0, {24'd0, power_ctl}, 32'h40);
      spi_if.ss = 1'b0;
      #(sclk_half);
      xfer(8'h0B, 8, rx);
      xfer(8'h2D, 8, rx);
      xfer(8'h00, 8, rx);
      chk("after_partial_read", 0, {24'd0, rx}, 32'h40);
      frame_end();
      $display("partial write: aborted after 5 data bits");

      // ---------------- reset asserted mid-read ----------------
      spi_if.ss = 1'b0;
      #(sclk_half);
      xfer(8'h0B, 8, rx);
      xfer(8'h00, 8, rx);
      #(sclk_half);
      chk("pre_reset_miso", 0, {31'd0, spi_if.miso}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("reset_miso", 0, {31'd0, spi_if.miso}, 32'd0);
      chk("reset_power", 0, {24'd0, power_ctl}, 32'h00);
      chk("reset_wr_valid", 0, {31'd0, wr_valid}, 32'd0);
      #49;
      rst_n = 1'b1;
      // Rest of the same frame must be ignored, including a full write.
      base = wr_cnt;
      xfer(8'h0A, 8, rx);
      chk("post_reset_miso", 0, {24'd0, rx}, 32'h00);
      xfer(8'h2D, 8, rx);
      xfer(8'h77, 8, rx);
      chk("post_reset_miso", 1, {24'd0, rx}, 32'h00);
      frame_end();
      chk("post_reset_wr_count", 0, wr_cnt - base, 0);
      chk("post_reset_power", 0, {24'd0, power_ctl}, 32'h00);
      spi_if.ss = 1'b0;
      #(sclk_half);
      xfer(8'h0B, 8, rx);
      xfer(8'h2C, 8, rx);
      xfer(8'h00, 8, rx);
      chk("post_reset_filter", 0, {24'd0, rx}, 32'h13);
      xfer(8'h00, 8, rx);
      chk("post_reset_pwr_rd", 0, {24'd0, rx}, 32'h00);
      frame_end();
      $display("reset mid-read: frame tail ignored, new frame decoded");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
